// File: rtl/bp_me_axi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bp_me_axi_rr_arbiter
// Brief   : Two-manager to one-subordinate AXI4 arbiter, independent
//           round-robin write (AW/W/B) and read (AR/R) paths, one outstanding
//           transaction per direction.
// Revision: 1.0
// ============================================================================
module bp_me_axi_rr_arbiter #(
  parameter int axi_addr_width_p = 64,
  parameter int axi_data_width_p = 64,
  parameter int axi_id_width_p   = 1,
  localparam int axi_strb_width_lp = axi_data_width_p / 8
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,

  // manager side, entry k = manager k
  input  logic [2*axi_addr_width_p-1:0]   s_axi_awaddr_i,
  input  logic [2*axi_id_width_p-1:0]     s_axi_awid_i,
  input  logic [15:0]                     s_axi_awlen_i,
  input  logic [5:0]                      s_axi_awsize_i,
  input  logic [3:0]                      s_axi_awburst_i,
  input  logic [1:0]                      s_axi_awvalid_i,
  output logic [1:0]                      s_axi_awready_o,

  input  logic [2*axi_data_width_p-1:0]   s_axi_wdata_i,
  input  logic [2*axi_strb_width_lp-1:0]  s_axi_wstrb_i,
  input  logic [1:0]                      s_axi_wlast_i,
  input  logic [1:0]                      s_axi_wvalid_i,
  output logic [1:0]                      s_axi_wready_o,

  output logic [2*axi_id_width_p-1:0]     s_axi_bid_o,
  output logic [3:0]                      s_axi_bresp_o,
  output logic [1:0]                      s_axi_bvalid_o,
  input  logic [1:0]                      s_axi_bready_i,

  input  logic [2*axi_addr_width_p-1:0]   s_axi_araddr_i,
  input  logic [2*axi_id_width_p-1:0]     s_axi_arid_i,
  input  logic [15:0]                     s_axi_arlen_i,
  input  logic [5:0]                      s_axi_arsize_i,
  input  logic [3:0]                      s_axi_arburst_i,
  input  logic [1:0]                      s_axi_arvalid_i,
  output logic [1:0]                      s_axi_arready_o,

  output logic [2*axi_data_width_p-1:0]   s_axi_rdata_o,
  output logic [2*axi_id_width_p-1:0]     s_axi_rid_o,
  output logic [1:0]                      s_axi_rlast_o,
  output logic [3:0]                      s_axi_rresp_o,
  output logic [1:0]                      s_axi_rvalid_o,
  input  logic [1:0]                      s_axi_rready_i,

  // subordinate side
  output logic [axi_addr_width_p-1:0]     m_axi_awaddr_o,
  output logic [axi_id_width_p-1:0]       m_axi_awid_o,
  output logic [7:0]                      m_axi_awlen_o,
  output logic [2:0]                      m_axi_awsize_o,
  output logic [1:0]                      m_axi_awburst_o,
  output logic                            m_axi_awvalid_o,
  input  logic                            m_axi_awready_i,

  output logic [axi_data_width_p-1:0]     m_axi_wdata_o,
  output logic [axi_strb_width_lp-1:0]    m_axi_wstrb_o,
  output logic                            m_axi_wlast_o,
  output logic                            m_axi_wvalid_o,
  input  logic                            m_axi_wready_i,

  input  logic [axi_id_width_p-1:0]       m_axi_bid_i,
  input  logic [1:0]                      m_axi_bresp_i,
  input  logic                            m_axi_bvalid_i,
  output logic                            m_axi_bready_o,

  output logic [axi_addr_width_p-1:0]     m_axi_araddr_o,
  output logic [axi_id_width_p-1:0]       m_axi_arid_o,
  output logic [7:0]                      m_axi_arlen_o,
  output logic [2:0]                      m_axi_arsize_o,
  output logic [1:0]                      m_axi_arburst_o,
  output logic                            m_axi_arvalid_o,
  input  logic                            m_axi_arready_i,

  input  logic [axi_data_width_p-1:0]     m_axi_rdata_i,
  input  logic [axi_id_width_p-1:0]       m_axi_rid_i,
  input  logic                            m_axi_rlast_i,
  input  logic [1:0]                      m_axi_rresp_i,
  input  logic                            m_axi_rvalid_i,
  output logic                            m_axi_rready_o
);

  localparam int A = axi_addr_width_p;
  localparam int D = axi_data_width_p;
  localparam int I = axi_id_width_p;
  localparam int S = axi_strb_width_lp;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_AW   = 2'd1;
  localparam logic [1:0] W_W    = 2'd2;
  localparam logic [1:0] W_B    = 2'd3;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_R    = 2'd2;

  logic [1:0] wstate_q, wstate_d;
  logic       wg_q, wg_d;
  logic       wptr_q, wptr_d;
  logic [1:0] rstate_q, rstate_d;
  logic       rg_q, rg_d;
  logic       rptr_q, rptr_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic in_aw, in_w, in_b, in_ar, in_r;

  // ptr names the manager that wins a tie; it moves to the other manager
  // only once a transaction fully completes.
  function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
    return (req == 2'b11) ? ptr : req[1];
  endfunction

  assign in_aw = (wstate_q == W_AW);
  assign in_w  = (wstate_q == W_W);
  assign in_b  = (wstate_q == W_B);
  assign in_ar = (rstate_q == R_AR);
  assign in_r  = (rstate_q == R_R);

  // Write path, subordinate side
  assign m_axi_awvalid_o = in_aw && s_axi_awvalid_i[wg_q];
  assign m_axi_awaddr_o  = in_aw ? (wg_q ? s_axi_awaddr_i[A +: A] : s_axi_awaddr_i[0 +: A]) : '0;
  assign m_axi_awid_o    = in_aw ? (wg_q ? s_axi_awid_i[I +: I]   : s_axi_awid_i[0 +: I])   : '0;
  assign m_axi_awlen_o   = in_aw ? (wg_q ? s_axi_awlen_i[15:8]    : s_axi_awlen_i[7:0])     : '0;
  assign m_axi_awsize_o  = in_aw ? (wg_q ? s_axi_awsize_i[5:3]    : s_axi_awsize_i[2:0])    : '0;
  assign m_axi_awburst_o = in_aw ? (wg_q ? s_axi_awburst_i[3:2]   : s_axi_awburst_i[1:0])   : '0;

  assign m_axi_wvalid_o  = in_w && s_axi_wvalid_i[wg_q];
  assign m_axi_wdata_o   = in_w ? (wg_q ? s_axi_wdata_i[D +: D] : s_axi_wdata_i[0 +: D]) : '0;
  assign m_axi_wstrb_o   = in_w ? (wg_q ? s_axi_wstrb_i[S +: S] : s_axi_wstrb_i[0 +: S]) : '0;
  assign m_axi_wlast_o   = in_w && s_axi_wlast_i[wg_q];

  assign m_axi_bready_o  = in_b && s_axi_bready_i[wg_q];

  assign aw_hs = m_axi_awvalid_o && m_axi_awready_i;
  assign w_hs  = m_axi_wvalid_o && m_axi_wready_i;
  assign b_hs  = m_axi_bvalid_i && m_axi_bready_o;

  // Read path, subordinate side
  assign m_axi_arvalid_o = in_ar && s_axi_arvalid_i[rg_q];
  assign m_axi_araddr_o  = in_ar ? (rg_q ? s_axi_araddr_i[A +: A] : s_axi_araddr_i[0 +: A]) : '0;
  assign m_axi_arid_o    = in_ar ? (rg_q ? s_axi_arid_i[I +: I]   : s_axi_arid_i[0 +: I])   : '0;
  assign m_axi_arlen_o   = in_ar ? (rg_q ? s_axi_arlen_i[15:8]    : s_axi_arlen_i[7:0])     : '0;
  assign m_axi_arsize_o  = in_ar ? (rg_q ? s_axi_arsize_i[5:3]    : s_axi_arsize_i[2:0])    : '0;
  assign m_axi_arburst_o = in_ar ? (rg_q ? s_axi_arburst_i[3:2]   : s_axi_arburst_i[1:0])   : '0;

  assign m_axi_rready_o  = in_r && s_axi_rready_i[rg_q];

  assign ar_hs = m_axi_arvalid_o && m_axi_arready_i;
  assign r_hs  = m_axi_rvalid_i && m_axi_rready_o;

  // Manager side: only the granted manager of each direction sees traffic
  for (genvar k = 0; k < 2; k++) begin : g_mgr
    logic wsel, rsel;
    assign wsel = (wg_q == 1'(k));
    assign rsel = (rg_q == 1'(k));

    assign s_axi_awready_o[k]      = in_aw && wsel && m_axi_awready_i;
    assign s_axi_wready_o[k]       = in_w && wsel && m_axi_wready_i;
    assign s_axi_bvalid_o[k]       = in_b && wsel && m_axi_bvalid_i;
    assign s_axi_bid_o[k*I +: I]   = (in_b && wsel) ? m_axi_bid_i : '0;
    assign s_axi_bresp_o[k*2 +: 2] = (in_b && wsel) ? m_axi_bresp_i : 2'b00;

    assign s_axi_arready_o[k]      = in_ar && rsel && m_axi_arready_i;
    assign s_axi_rvalid_o[k]       = in_r && rsel && m_axi_rvalid_i;
    assign s_axi_rdata_o[k*D +: D] = (in_r && rsel) ? m_axi_rdata_i : '0;
    assign s_axi_rid_o[k*I +: I]   = (in_r && rsel) ? m_axi_rid_i : '0;
    assign s_axi_rlast_o[k]        = in_r && rsel && m_axi_rlast_i;
    assign s_axi_rresp_o[k*2 +: 2] = (in_r && rsel) ? m_axi_rresp_i : 2'b00;
  end

  always_comb begin
    wstate_d = wstate_q;
    wg_d     = wg_q;
    wptr_d   = wptr_q;
    unique case (wstate_q)
      W_IDLE: begin
        if (|s_axi_awvalid_i) begin
          wg_d     = rr_pick(s_axi_awvalid_i, wptr_q);
          wstate_d = W_AW;
        end
      end
      W_AW: if (aw_hs) wstate_d = W_W;
      W_W:  if (w_hs && m_axi_wlast_o) wstate_d = W_B;
      W_B: begin
        if (b_hs) begin
          wstate_d = W_IDLE;
          wptr_d   = ~wg_q;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rg_d     = rg_q;
    rptr_d   = rptr_q;
    unique case (rstate_q)
      R_IDLE: begin
        if (|s_axi_arvalid_i) begin
          rg_d     = rr_pick(s_axi_arvalid_i, rptr_q);
          rstate_d = R_AR;
        end
      end
      R_AR: if (ar_hs) rstate_d = R_R;
      R_R: begin
        if (r_hs && m_axi_rlast_i) begin
          rstate_d = R_IDLE;
          rptr_d   = ~rg_q;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wstate_q <= W_IDLE;
      wg_q     <= 1'b0;
      wptr_q   <= 1'b0;
      rstate_q <= R_IDLE;
      rg_q     <= 1'b0;
      rptr_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      wg_q     <= wg_d;
      wptr_q   <= wptr_d;
      rstate_q <= rstate_d;
      rg_q     <= rg_d;
      rptr_q   <= rptr_d;
    end
  end

`ifndef SYNTHESIS
  // Returned IDs are forwarded untouched; this only flags a subordinate
  // that answers with an ID other than the one it was given.
  logic [I-1:0] awid_q, awid_d, arid_q, arid_d;

  always_comb begin
    awid_d = aw_hs ? m_axi_awid_o : awid_q;
    arid_d = ar_hs ? m_axi_arid_o : arid_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      awid_q <= '0;
      arid_q <= '0;
    end else begin
      awid_q <= awid_d;
      arid_q <= arid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && b_hs) begin
      assert (m_axi_bid_i == awid_q) else $error("bid differs from granted awid");
    end
    if (reset_n_i && r_hs) begin
      assert (m_axi_rid_i == arid_q) else $error("rid differs from granted arid");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_me_axi_rr_arbiter.sv
`default_nettype none
// Directed bench for bp_me_axi_rr_arbiter; the bench itself plays both
// managers and the subordinate, expected values flow through a scoreboard.
module tb_bp_me_axi_rr_arbiter;
  localparam int A = 64;
  localparam int D = 64;
  localparam int I = 1;
  localparam int S = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [2*A-1:0] s_awaddr;  logic [2*I-1:0] s_awid;  logic [15:0] s_awlen;
  logic [5:0] s_awsize;      logic [3:0] s_awburst;   logic [1:0] s_awvalid, s_awready;
  logic [2*D-1:0] s_wdata;   logic [2*S-1:0] s_wstrb; logic [1:0] s_wlast, s_wvalid, s_wready;
  logic [2*I-1:0] s_bid;     logic [3:0] s_bresp;     logic [1:0] s_bvalid, s_bready;
  logic [2*A-1:0] s_araddr;  logic [2*I-1:0] s_arid;  logic [15:0] s_arlen;
  logic [5:0] s_arsize;      logic [3:0] s_arburst;   logic [1:0] s_arvalid, s_arready;
  logic [2*D-1:0] s_rdata;   logic [2*I-1:0] s_rid;   logic [1:0] s_rlast;
  logic [3:0] s_rresp;       logic [1:0] s_rvalid, s_rready;

  logic [A-1:0] m_awaddr;  logic [I-1:0] m_awid;  logic [7:0] m_awlen;  logic [2:0] m_awsize;
  logic [1:0] m_awburst;   logic m_awvalid, m_awready;
  logic [D-1:0] m_wdata;   logic [S-1:0] m_wstrb; logic m_wlast, m_wvalid, m_wready;
  logic [I-1:0] m_bid;     logic [1:0] m_bresp;   logic m_bvalid, m_bready;
  logic [A-1:0] m_araddr;  logic [I-1:0] m_arid;  logic [7:0] m_arlen;  logic [2:0] m_arsize;
  logic [1:0] m_arburst;   logic m_arvalid, m_arready;
  logic [D-1:0] m_rdata;   logic [I-1:0] m_rid;   logic m_rlast;
  logic [1:0] m_rresp;     logic m_rvalid, m_rready;

  bp_me_axi_rr_arbiter #(.axi_addr_width_p(A), .axi_data_width_p(D), .axi_id_width_p(I)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .s_axi_awaddr_i(s_awaddr), .s_axi_awid_i(s_awid), .s_axi_awlen_i(s_awlen),
    .s_axi_awsize_i(s_awsize), .s_axi_awburst_i(s_awburst),
    .s_axi_awvalid_i(s_awvalid), .s_axi_awready_o(s_awready),
    .s_axi_wdata_i(s_wdata), .s_axi_wstrb_i(s_wstrb), .s_axi_wlast_i(s_wlast),
    .s_axi_wvalid_i(s_wvalid), .s_axi_wready_o(s_wready),
    .s_axi_bid_o(s_bid), .s_axi_bresp_o(s_bresp), .s_axi_bvalid_o(s_bvalid), .s_axi_bready_i(s_bready),
    .s_axi_araddr_i(s_araddr), .s_axi_arid_i(s_arid), .s_axi_arlen_i(s_arlen),
    .s_axi_arsize_i(s_arsize), .s_axi_arburst_i(s_arburst),
    .s_axi_arvalid_i(s_arvalid), .s_axi_arready_o(s_arready),
    .s_axi_rdata_o(s_rdata), .s_axi_rid_o(s_rid), .s_axi_rlast_o(s_rlast), .s_axi_rresp_o(s_rresp),
    .s_axi_rvalid_o(s_rvalid), .s_axi_rready_i(s_rready),
    .m_axi_awaddr_o(m_awaddr), .m_axi_awid_o(m_awid), .m_axi_awlen_o(m_awlen),
    .m_axi_awsize_o(m_awsize), .m_axi_awburst_o(m_awburst),
    .m_axi_awvalid_o(m_awvalid), .m_axi_awready_i(m_awready),
    .m_axi_wdata_o(m_wdata), .m_axi_wstrb_o(m_wstrb), .m_axi_wlast_o(m_wlast),
    .m_axi_wvalid_o(m_wvalid), .m_axi_wready_i(m_wready),
    .m_axi_bid_i(m_bid), .m_axi_bresp_i(m_bresp), .m_axi_bvalid_i(m_bvalid), .m_axi_bready_o(m_bready),
    .m_axi_araddr_o(m_araddr), .m_axi_arid_o(m_arid), .m_axi_arlen_o(m_arlen),
    .m_axi_arsize_o(m_arsize), .m_axi_arburst_o(m_arburst),
    .m_axi_arvalid_o(m_arvalid), .m_axi_arready_i(m_arready),
    .m_axi_rdata_i(m_rdata), .m_axi_rid_i(m_rid), .m_axi_rlast_i(m_rlast), .m_axi_rresp_i(m_rresp),
    .m_axi_rvalid_i(m_rvalid), .m_axi_rready_o(m_rready)
  );

  logic [14:0] all_vr;
  assign all_vr = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
                   s_awready, s_wready, s_bvalid, s_arready, s_rvalid};

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { string tag; logic [63:0] val; } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int idx;
    logic tog;

    // ---------------- reset: everything requesting, nothing may pass
    s_awaddr = '1; s_awid = 2'b10; s_awlen = '0; s_awsize = {3'd3, 3'd3}; s_awburst = 4'b0101;
    s_awvalid = 2'b11; s_wdata = '1; s_wstrb = '1; s_wlast = 2'b11; s_wvalid = 2'b11;
    s_bready = 2'b11; s_araddr = '1; s_arid = 2'b10; s_arlen = '0; s_arsize = {3'd3, 3'd3};
    s_arburst = 4'b0101; s_arvalid = 2'b11; s_rready = 2'b11;
    m_awready = 1'b1; m_wready = 1'b1; m_bid = '0; m_bresp = '0; m_bvalid = 1'b1;
    m_arready = 1'b1; m_rdata = '0; m_rid = '0; m_rlast = 1'b0; m_rresp = '0; m_rvalid = 1'b1;
    nx(); settle();
    chk("reset_valid_ready", 64'(all_vr), 64'd0);
    chk("reset_awaddr", m_awaddr, 64'd0);
    nx();
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0; m_bvalid = 1'b0; m_rvalid = 1'b0;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0; s_wlast = '0;
    nx(); reset_n = 1'b1;

    // ---------------- 1: single write from mgr0
    nx();
    s_awvalid = 2'b01; s_awaddr[63:0] = 64'h8000_0000; s_awlen[7:0] = 8'd0;
    push("t1_awaddr", 64'h8000_0000);
    settle();
    chk("t1_arb_latency", 64'(m_awvalid), 64'd0);
    nx(); settle();
    chk("t1_awvalid", 64'(m_awvalid), 64'd1);
    chk("t1_awready", 64'(s_awready), 64'd1);
    pop_chk(m_awaddr);
    nx();
    s_awvalid = 2'b00; s_wvalid = 2'b01; s_wdata[63:0] = 64'hDEAD_BEEF; s_wlast = 2'b01;
    push("t1_wdata", 64'hDEAD_BEEF);
    settle();
    chk("t1_wready", 64'(s_wready), 64'd1);
    pop_chk(m_wdata);
    nx();
    s_wvalid = 2'b00; m_bvalid = 1'b1; m_bid = 1'b0; m_bresp = 2'b00;
    push("t1_bvalid_mgr0_only", 64'd1);
    settle();
    pop_chk(64'(s_bvalid));
    chk("t1_bresp", 64'(s_bresp), 64'd0);
    chk("t1_bready", 64'(m_bready), 64'd1);
    nx(); m_bvalid = 1'b0; settle();
    chk("t1_idle", 64'(s_bvalid), 64'd0);

    // ---------------- 2: simultaneous AR from reset, round robin
    nx();
    s_arvalid = 2'b11; s_araddr[63:0] = 64'h1000; s_araddr[127:64] = 64'h2000;
    push("t2_round1_addr", 64'h1000);
    settle();
    chk("t2_arb_latency", 64'(m_arvalid), 64'd0);
    nx(); settle();
    pop_chk(m_araddr);
    chk("t2_round1_arready", 64'(s_arready), 64'd1);
    nx();
    s_arvalid[0] = 1'b0; m_rvalid = 1'b1; m_rdata = 64'hA0; m_rlast = 1'b1; m_rid = 1'b0;
    push("t2_round1_rdata", 64'hA0);
    settle();
    chk("t2_round1_rvalid", 64'(s_rvalid), 64'd1);
    pop_chk(s_rdata[63:0]);
    nx();
    m_rvalid = 1'b0; s_arvalid[0] = 1'b1;
    push("t2_round2_addr", 64'h2000);
    nx(); settle();
    pop_chk(m_araddr);
    chk("t2_round2_arready", 64'(s_arready), 64'd2);
    nx();
    s_arvalid[1] = 1'b0; m_rvalid = 1'b1; m_rdata = 64'hB0; m_rid = 1'b1;
    push("t2_round2_rdata", 64'hB0);
    settle();
    chk("t2_round2_rvalid", 64'(s_rvalid), 64'd2);
    pop_chk(s_rdata[127:64]);
    nx();
    m_rvalid = 1'b0; s_arvalid = 2'b11; s_araddr[127:64] = 64'h3000; s_arlen[15:8] = 8'd3;
    push("t2_round3_addr", 64'h1000);
    nx(); settle();
    pop_chk(m_araddr);
    chk("t2_round3_arready", 64'(s_arready), 64'd1);
    nx();
    s_arvalid[0] = 1'b0; m_rvalid = 1'b1; m_rdata = 64'hA1; m_rid = 1'b0;
    push("t2_round3_rdata", 64'hA1);
    settle();
    pop_chk(s_rdata[63:0]);

    // ---------------- 3: mgr1 burst of 4 while mgr0 AR waits
    nx();
    m_rvalid = 1'b0; s_arvalid[0] = 1'b1; s_araddr[63:0] = 64'h5000;
    push("t3_burst_addr", 64'h3000);
    nx(); settle();
    pop_chk(m_araddr);
    chk("t3_arlen", 64'(m_arlen), 64'd3);
    for (int i = 0; i < 4; i++) begin
      nx();
      s_arvalid[1] = 1'b0;
      m_rvalid = 1'b1; m_rdata = 64'hC0 + 64'(i); m_rlast = (i == 3); m_rid = 1'b1;
      push("t3_beat_data", 64'hC0 + 64'(i));
      settle();
      pop_chk(s_rdata[127:64]);
      chk("t3_rlast", 64'(s_rlast), (i == 3) ? 64'd2 : 64'd0);
      chk("t3_pending_ar_held", 64'(m_arvalid), 64'd0);
    end
    nx();
    m_rvalid = 1'b0;
    push("t3_pending_addr", 64'h5000);
    nx(); settle();
    pop_chk(m_araddr);
    nx();
    s_arvalid[0] = 1'b0; m_rvalid = 1'b1; m_rdata = 64'hD0; m_rlast = 1'b1; m_rid = 1'b0;
    push("t3_pending_rdata", 64'hD0);
    settle();
    pop_chk(s_rdata[63:0]);

    // ---------------- 4: concurrent mgr0 write and mgr1 read
    nx();
    m_rvalid = 1'b0;
    s_awvalid = 2'b01; s_awaddr[63:0] = 64'h9000; s_awlen[7:0] = 8'd0;
    s_arvalid = 2'b10; s_araddr[127:64] = 64'h6000; s_arlen[15:8] = 8'd0;
    push("t4_awaddr", 64'h9000);
    push("t4_araddr", 64'h6000);
    nx(); settle();
    chk("t4_both_valid", 64'({m_awvalid, m_arvalid}), 64'd3);
    pop_chk(m_awaddr);
    pop_chk(m_araddr);
    chk("t4_awready", 64'(s_awready), 64'd1);
    chk("t4_arready", 64'(s_arready), 64'd2);
    nx();
    s_awvalid = 2'b00; s_arvalid = 2'b00;
    s_wvalid = 2'b01; s_wdata[63:0] = 64'h1111; s_wlast = 2'b01;
    m_rvalid = 1'b1; m_rdata = 64'h2222; m_rlast = 1'b1; m_rid = 1'b1;
    push("t4_wdata", 64'h1111);
    push("t4_rdata", 64'h2222);
    settle();
    pop_chk(m_wdata);
    pop_chk(s_rdata[127:64]);
    nx();
    s_wvalid = 2'b00; m_rvalid = 1'b0; m_bvalid = 1'b1; m_bid = 1'b0; m_bresp = 2'b10;
    push("t4_bresp", 64'h2);
    settle();
    pop_chk(64'(s_bresp[1:0]));
    chk("t4_read_done", 64'(s_rvalid), 64'd0);
    nx(); m_bvalid = 1'b0; m_bresp = 2'b00;

    // ---------------- 5: backpressure on R and B
    nx();
    s_arvalid = 2'b01; s_araddr[63:0] = 64'h7000; s_arlen[7:0] = 8'd3;
    nx(); settle();
    chk("t5_arready", 64'(s_arready), 64'd1);
    for (int i = 0; i < 4; i++) push("t5_beat_data", 64'hE0 + 64'(i));
    idx = 0;
    tog = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      nx();
      s_arvalid = 2'b00;
      m_rvalid = 1'b1; m_rdata = 64'hE0 + 64'(idx); m_rlast = (idx == 3); m_rid = 1'b0;
      s_rready = {1'b0, tog};
      settle();
      chk("t5_rready_pass", 64'(m_rready), 64'(tog));
      if (m_rready) begin
        pop_chk(s_rdata[63:0]);
        idx++;
      end
      tog = ~tog;
    end
    chk("t5_beat_count", 64'(idx), 64'd4);
    nx();
    m_rvalid = 1'b0; s_rready = 2'b11;
    settle();
    chk("t5_read_idle", 64'(s_rvalid), 64'd0);
    nx();
    s_awvalid = 2'b10; s_awaddr[127:64] = 64'hA000; s_awlen[15:8] = 8'd0;
    nx(); settle();
    chk("t5_awready", 64'(s_awready), 64'd2);
    nx();
    s_awvalid = 2'b00; s_wvalid = 2'b10; s_wdata[127:64] = 64'h3333; s_wlast = 2'b10;
    settle();
    chk("t5_wready", 64'(s_wready), 64'd2);
    nx();
    s_wvalid = 2'b00; m_bvalid = 1'b1; m_bid = 1'b1; s_bready = 2'b00;
    settle();
    chk("t5_bready_held", 64'(m_bready), 64'd0);
    chk("t5_bvalid_held", 64'(s_bvalid), 64'd2);
    nx();
    s_bready = 2'b10;
    settle();
    chk("t5_bready_released", 64'(m_bready), 64'd1);
    chk("t5_bvalid_kept", 64'(s_bvalid), 64'd2);
    nx();
    m_bvalid = 1'b0; s_bready = 2'b11;
    settle();
    chk("t5_write_idle", 64'(s_bvalid), 64'd0);

    // ---------------- 6: reset in the middle of a 2-beat write
    nx();
    s_awvalid = 2'b01; s_awaddr[63:0] = 64'hB000; s_awlen[7:0] = 8'd1;
    nx(); settle();
    chk("t6_awready", 64'(s_awready), 64'd1);
    nx();
    s_awvalid = 2'b00; s_wvalid = 2'b01; s_wdata[63:0] = 64'hF0; s_wlast = 2'b00;
    settle();
    chk("t6_first_beat_wready", 64'(s_wready), 64'd1);
    nx();
    s_wdata[63:0] = 64'hF1; s_wlast = 2'b01; reset_n = 1'b0;
    settle();
    chk("t6_reset_valid_ready", 64'(all_vr), 64'd0);
    nx();
    reset_n = 1'b1; s_wvalid = 2'b00; s_wlast = 2'b00;
    settle();
    chk("t6_post_reset_idle", 64'(all_vr), 64'd0);
    nx();
    s_awvalid = 2'b01; s_awaddr[63:0] = 64'hC000; s_awlen[7:0] = 8'd0;
    push("t6_new_awaddr", 64'hC000);
    nx(); settle();
    pop_chk(m_awaddr);
    nx();
    s_awvalid = 2'b00; s_wvalid = 2'b01; s_wdata[63:0] = 64'h4444; s_wlast = 2'b01;
    push("t6_new_wdata", 64'h4444);
    settle();
    pop_chk(m_wdata);
    nx();
    s_wvalid = 2'b00; m_bvalid = 1'b1; m_bid = 1'b0; m_bresp = 2'b00;
    push("t6_new_bvalid", 64'd1);
    settle();
    pop_chk(64'(s_bvalid));
    nx();
    m_bvalid = 1'b0;

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
